// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller (package all_pkgs).
package all_pkgs;

    typedef enum logic [1:0] {
        RST_FLUSH = 2'd0,
        RUN       = 2'd1,
        MEM_WAIT  = 2'd2
    } pipe_ctrl_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Load-use comparator: flags an ID source that depends on a load still in EX.
module hazard_cmp
    import all_pkgs::*;
(
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_use_rs1,
    input  logic       i_id_use_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_reg_wr_en,
    input  logic       i_ex_mem_to_reg,
    output logic       o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign o_load_use = i_ex_mem_to_reg && i_ex_reg_wr_en && (i_ex_rd != REG_X0)
                        && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: reset flush, memory-wait stall, branch redirect, load-use stall.
// Optional performance counters (stall_cnt, flush_cnt) are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import all_pkgs::*;
#(
    parameter int unsigned RST_FLUSH_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_wr_en,
    input  logic             ex_mem_to_reg,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             redirect,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt,
`endif
    output pipe_ctrl_state_t o_dbg_state
);

    localparam logic [3:0] CNT_INIT = 4'(RST_FLUSH_CYC - 1);

    pipe_ctrl_state_t r_state;
    pipe_ctrl_state_t w_next_state;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic             r_pend;
    logic             w_pend_nxt;
    logic             w_load_use;

    hazard_cmp u_hazard_cmp (
        .i_id_rs1        (id_rs1),
        .i_id_rs2        (id_rs2),
        .i_id_use_rs1    (id_use_rs1),
        .i_id_use_rs2    (id_use_rs2),
        .i_ex_rd         (ex_rd),
        .i_ex_reg_wr_en  (ex_reg_wr_en),
        .i_ex_mem_to_reg (ex_mem_to_reg),
        .o_load_use      (w_load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_FLUSH;
            r_cnt   <= CNT_INIT;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        redirect     = 1'b0;
        w_next_state = r_state;
        w_cnt_nxt    = r_cnt;
        w_pend_nxt   = r_pend;
        case (r_state)
            RST_FLUSH: begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_next_state = RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            // The first MEM_WAIT cycle with mem_busy low already acts as RUN,
            // so a held branch redirects with no extra bubble.
            RUN, MEM_WAIT: begin
                if (mem_busy) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    w_next_state = MEM_WAIT;
                    if (br_taken) begin
                        w_pend_nxt = 1'b1;
                    end
                end else begin
                    w_next_state = RUN;
                    if (br_taken || r_pend) begin
                        redirect    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        w_pend_nxt  = 1'b0;
                    end else if (w_load_use) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = RST_FLUSH;
            end
        endcase
    end

    assign o_dbg_state = r_state;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if ((r_state != RST_FLUSH) && pc_stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (redirect) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_pipe_ctrl;
    import all_pkgs::*;

    localparam int RST_FLUSH_CYC = 2;

    // Expected output vectors, ordered {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, redirect}
    localparam logic [6:0] OUT_NONE  = 7'b0000000;
    localparam logic [6:0] OUT_FLUSH = 7'b1010100;
    localparam logic [6:0] OUT_MEMW  = 7'b1101010;
    localparam logic [6:0] OUT_REDIR = 7'b0010101;
    localparam logic [6:0] OUT_LU    = 7'b1100100;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, ex_reg_wr_en, ex_mem_to_reg, br_taken, mem_busy;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, redirect;
    pipe_ctrl_state_t dbg_state;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_ctrl #(.RST_FLUSH_CYC(RST_FLUSH_CYC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .ex_rd         (ex_rd),
        .ex_reg_wr_en  (ex_reg_wr_en),
        .ex_mem_to_reg (ex_mem_to_reg),
        .br_taken      (br_taken),
        .mem_busy      (mem_busy),
        .pc_stall      (pc_stall),
        .if_id_stall   (if_id_stall),
        .if_id_flush   (if_id_flush),
        .id_ex_stall   (id_ex_stall),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_stall  (ex_mem_stall),
        .redirect      (redirect),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
`endif
        .o_dbg_state   (dbg_state)
    );

    logic [6:0] dut_v;
    assign dut_v = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, redirect};

    int checks   = 0;
    int failures = 0;

    // Reference model: cycles of flush left after reset, one pending-branch bit, event counts.
    int          m_flush_left;
    bit          m_pend;
    logic [31:0] m_stall_cnt;
    logic [31:0] m_flush_cnt;

    function automatic logic m_load_use();
        if (!(ex_mem_to_reg && ex_reg_wr_en) || ex_rd == 5'd0) return 1'b0;
        return (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
    endfunction

    function automatic logic [6:0] model_out();
        if (!rst_n || m_flush_left > 0) return OUT_FLUSH;
        if (mem_busy)                   return OUT_MEMW;
        if (br_taken || m_pend)         return OUT_REDIR;
        if (m_load_use())               return OUT_LU;
        return OUT_NONE;
    endfunction

    task automatic model_step();
        logic [6:0] e;
        e = model_out();
        if (!rst_n) begin
            m_flush_left = RST_FLUSH_CYC;
            m_pend       = 1'b0;
            m_stall_cnt  = 32'd0;
            m_flush_cnt  = 32'd0;
        end else if (m_flush_left > 0) begin
            m_flush_left = m_flush_left - 1;
        end else begin
            if (e[6]) m_stall_cnt = m_stall_cnt + 32'd1;
            if (e[0]) m_flush_cnt = m_flush_cnt + 32'd1;
            if (mem_busy) begin
                if (br_taken) m_pend = 1'b1;
            end else if (e[0]) begin
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_reg_wr_en = 1'b0; ex_mem_to_reg = 1'b0;
        br_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic test_reset();
        int flush_cycles;
        logic [6:0] e;
        clear_inputs();
        rst_n = 1'b0;
        #1;
        e = model_out();
        checks++;
        if (dut_v !== e) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=%b", dut_v, e);
        end
        checks++;
        if (dbg_state !== RST_FLUSH) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=%0d", dbg_state, RST_FLUSH);
        end
        tick();
        tick();
        rst_n = 1'b1;
        flush_cycles = 0;
        for (int i = 0; i < RST_FLUSH_CYC + 3; i++) begin
            @(negedge clk);
            e = model_out();
            if (id_ex_flush) flush_cycles++;
            checks++;
            if (dut_v !== e) begin
                failures++;
                $display("FAIL reset_release cyc=%0d got=%b exp=%b", i, dut_v, e);
            end
            tick();
        end
        checks++;
        if (flush_cycles != RST_FLUSH_CYC) begin
            failures++;
            $display("FAIL reset_flush_len got=%0d exp=%0d", flush_cycles, RST_FLUSH_CYC);
        end
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL perf_after_reset got=%0d exp=0", stall_cnt);
        end
`endif
    endtask

    task automatic test_mem_busy();
        int stall_cycles;
        logic [6:0] e;
        clear_inputs();
        stall_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            mem_busy = (i < 3);
            @(negedge clk);
            e = model_out();
            if (ex_mem_stall) stall_cycles++;
            checks++;
            if (dut_v !== e) begin
                failures++;
                $display("FAIL mem_busy cyc=%0d got=%b exp=%b", i, dut_v, e);
            end
            tick();
        end
        checks++;
        if (stall_cycles != 3) begin
            failures++;
            $display("FAIL mem_busy_len got=%0d exp=3", stall_cycles);
        end
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (stall_cnt !== 32'd3) begin
            failures++;
            $display("FAIL perf_stall_cnt got=%0d exp=3", stall_cnt);
        end
`endif
    endtask

    task automatic test_load_use();
        logic [6:0] e;
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            ex_mem_to_reg = 1'b1;
            ex_reg_wr_en  = 1'b1;
            ex_rd         = (i == 1 || i == 3) ? 5'd0 : 5'd5;
            if (i < 2) begin
                id_rs2 = ex_rd; id_use_rs2 = 1'b1; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
            end else begin
                id_rs1 = ex_rd; id_use_rs1 = 1'b1; id_rs2 = 5'd9;
            end
            @(negedge clk);
            e = model_out();
            checks++;
            if (dut_v !== e) begin
                failures++;
                $display("FAIL load_use case=%0d got=%b exp=%b", i, dut_v, e);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_branch_in_wait();
        logic [6:0] e;
        clear_inputs();
        for (int i = 0; i < 6; i++) begin
            mem_busy = (i < 4);
            br_taken = (i == 1);
            @(negedge clk);
            e = model_out();
            checks++;
            if (dut_v !== e) begin
                failures++;
                $display("FAIL branch_in_wait cyc=%0d got=%b exp=%b", i, dut_v, e);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_br_vs_load_use();
        logic [6:0] e;
        clear_inputs();
        ex_mem_to_reg = 1'b1; ex_reg_wr_en = 1'b1; ex_rd = 5'd12;
        id_rs1 = 5'd12; id_use_rs1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            br_taken = (i == 0);
            @(negedge clk);
            e = model_out();
            checks++;
            if (dut_v !== e) begin
                failures++;
                $display("FAIL br_vs_load_use cyc=%0d got=%b exp=%b", i, dut_v, e);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_pending();
        int redirects;
        logic [6:0] e;
        clear_inputs();
        mem_busy = 1'b1;
        br_taken = 1'b1;
        tick();
        br_taken = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        e = model_out();
        checks++;
        if (dut_v !== e) begin
            failures++;
            $display("FAIL reset_mid_wait got=%b exp=%b", dut_v, e);
        end
        tick();
        tick();
        rst_n    = 1'b1;
        mem_busy = 1'b0;
        redirects = 0;
        for (int i = 0; i < RST_FLUSH_CYC + 3; i++) begin
            @(negedge clk);
            e = model_out();
            if (redirect) redirects++;
            checks++;
            if (dut_v !== e) begin
                failures++;
                $display("FAIL reset_pending cyc=%0d got=%b exp=%b", i, dut_v, e);
            end
            tick();
        end
        checks++;
        if (redirects != 0) begin
            failures++;
            $display("FAIL reset_pending_redir got=%0d exp=0", redirects);
        end
    endtask

    task automatic test_random();
        logic [6:0] e;
        for (int i = 0; i < 400; i++) begin
            rst_n         = ($urandom_range(0, 99) != 0);
            mem_busy      = ($urandom_range(0, 3) == 0);
            br_taken      = ($urandom_range(0, 5) == 0);
            ex_rd         = 5'($urandom_range(0, 3));
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            id_use_rs1    = 1'($urandom_range(0, 1));
            id_use_rs2    = 1'($urandom_range(0, 1));
            ex_reg_wr_en  = ($urandom_range(0, 3) != 0);
            ex_mem_to_reg = 1'($urandom_range(0, 1));
            #1;
            e = model_out();
            checks++;
            if (dut_v !== e) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, dut_v, e);
            end
            tick();
        end
        rst_n = 1'b1;
        clear_inputs();
        for (int i = 0; i < RST_FLUSH_CYC + 1; i++) tick();
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (stall_cnt !== m_stall_cnt) begin
            failures++;
            $display("FAIL perf_stall_random got=%0d exp=%0d", stall_cnt, m_stall_cnt);
        end
        checks++;
        if (flush_cnt !== m_flush_cnt) begin
            failures++;
            $display("FAIL perf_flush_random got=%0d exp=%0d", flush_cnt, m_flush_cnt);
        end
`endif
    endtask

    initial begin
        m_flush_left = RST_FLUSH_CYC;
        m_pend       = 1'b0;
        m_stall_cnt  = 32'd0;
        m_flush_cnt  = 32'd0;
        test_reset();
        test_mem_busy();
        test_load_use();
        test_branch_in_wait();
        test_br_vs_load_use();
        test_reset_pending();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter RST_FLUSH_CYC, default 2, meaning the number of post-reset cycles with both pipeline registers flushed (legal range 1..15).
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port id_rs1, id_rs2  in  5 each  ID-stage source register indices.
REQ-005 SHALL have port id_use_rs1, id_use_rs2  in  1 each  the ID instruction reads that source.
REQ-006 SHALL have port ex_rd  in  5  EX-stage destination index.
REQ-007 SHALL have port ex_reg_wr_en, ex_mem_to_reg  in  1 each  EX instruction writes rd / is a load.
REQ-008 SHALL have port br_taken  in  1  single-cycle pulse: EX resolved a taken branch or jump.
REQ-009 SHALL have port mem_busy  in  1  data memory not ready; level signal.
REQ-010 SHALL have ports pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall  out  1 each  pipeline-register hold and bubble controls.
REQ-011 SHALL have port redirect  out  1  one-cycle strobe selecting the branch target at the PC mux.

Function
REQ-012 SHALL implement FSM states RST_FLUSH, RUN, MEM_WAIT.
REQ-013 RST_FLUSH: pc_stall=1, if_id_flush=1, id_ex_flush=1, all other outputs 0; a 4-bit down-counter loaded with RST_FLUSH_CYC-1 at reset; exit to RUN in the cycle after the counter reads 0.
REQ-014 RUN with mem_busy=1: go to MEM_WAIT; in the same cycle, pc_stall, if_id_stall, id_ex_stall and ex_mem_stall are 1 and both flushes are 0.
REQ-015 MEM_WAIT: all four stall outputs are 1, both flushes are 0 and redirect is 0; return to RUN in the first cycle mem_busy=0.
REQ-016 A br_taken pulse arriving in MEM_WAIT, or in the RUN cycle that enters MEM_WAIT, SHALL set a pending_redir flag instead of acting immediately.
REQ-017 Redirect: in RUN with mem_busy=0 and (br_taken or pending_redir): redirect=1, if_id_flush=1, id_ex_flush=1, pc_stall=0; pending_redir is cleared at that clock edge.
REQ-018 Load-use: in RUN with mem_busy=0 and no redirect, when ex_mem_to_reg & ex_reg_wr_en & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)): pc_stall=1, if_id_stall=1, id_ex_flush=1; other outputs 0.
REQ-019 Priority SHALL be reset-flush > mem_busy > redirect > load-use.
REQ-020 No other hazard in RUN: all outputs 0.
REQ-021 Outputs SHALL be combinational from the state, the counter, pending_redir and the inputs; there SHALL be no additional latency.
REQ-022 Writes to x0 SHALL never cause a stall.

Reset
REQ-023 rst_n low SHALL force the state to RST_FLUSH, load the counter with RST_FLUSH_CYC-1 and clear pending_redir, all asynchronously.
REQ-024 While rst_n is low, outputs SHALL be pc_stall=1, if_id_flush=1, id_ex_flush=1 and all others 0.
REQ-025 Reset asserted mid-MEM_WAIT SHALL discard pending_redir.

Configuration
REQ-026 With PIPE_CTRL_PERF_EN defined, the block SHALL add outputs stall_cnt[31:0] and flush_cnt[31:0].
REQ-027 stall_cnt SHALL count cycles with pc_stall=1 in RUN/MEM_WAIT; flush_cnt SHALL count redirect strobes.
REQ-028 Both counters SHALL wrap at 2^32 and reset to 0.
REQ-029 Without PIPE_CTRL_PERF_EN, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-030 The state enum pipe_ctrl_state_t and the constant REG_X0=5'd0 SHALL live in all_pkgs.
REQ-031 The load-use comparator SHALL be the sub-module hazard_cmp (pure combinational).

Verification
REQ-032 Reset release with RST_FLUSH_CYC=2 -> id_ex_flush=1 for exactly 2 cycles, then all outputs 0.
REQ-033 ex_rd=5, ex_mem_to_reg=1, ex_reg_wr_en=1, id_rs2=5, id_use_rs2=1 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; the same stimulus with ex_rd=0 -> no stall.
REQ-034 mem_busy high for 3 cycles -> all stalls 1 for 3 cycles, then 0.
REQ-035 br_taken pulse on the 2nd cycle of a 4-cycle mem_busy -> redirect=1 with both flushes exactly in the first cycle after mem_busy falls.
REQ-036 br_taken coincident with load-use match -> redirect and flushes asserted, no pc_stall.
REQ-037 rst_n asserted with pending_redir set -> no redirect after release; with PIPE_CTRL_PERF_EN, stall_cnt=0 after reset and =3 after REQ-034.
